fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO words and output data.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of burst length and counters.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle burst request.
REQ-006 SHALL have port burst_len  input  LEN_WIDTH  words to transfer; sampled with start.
REQ-007 SHALL have port fifo_empty  input  1  empty flag from the FIFO read side.
REQ-008 SHALL have port fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
REQ-009 SHALL have port fifo_rd_en  output  1  FIFO pop request.
REQ-010 SHALL have port m_data  output  DATA_WIDTH  output stream data.
REQ-011 SHALL have port m_valid  output  1  m_data valid.
REQ-012 SHALL have port m_ready  input  1  downstream accept; a transfer occurs when m_valid and m_ready are both high.
REQ-013 SHALL have port busy  output  1  high in RUN and DONE.
REQ-014 SHALL have port done  output  1  one-cycle pulse at burst end.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 SHALL go IDLE->RUN on start with burst_len!=0, loading issue_cnt and deliver_cnt with burst_len.
REQ-017 SHALL go IDLE->DONE on start with burst_len==0; no FIFO reads.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL drive fifo_rd_en combinationally = RUN && !fifo_empty && issue_cnt!=0 && (occ + inflight - pop) < 2, where occ is the output buffer occupancy (0..2), inflight is the registered fifo_rd_en of the previous cycle, and pop = m_valid && m_ready.
REQ-020 SHALL never assert fifo_rd_en while fifo_empty is high; each assertion decrements issue_cnt.
REQ-021 SHALL capture fifo_rd_data into a 2-entry in-order output buffer on the edge ending the cycle after fifo_rd_en.
REQ-022 SHALL give latency of fifo_rd_en in cycle N to m_valid in cycle N+2 when the buffer was empty.
REQ-023 SHALL sustain 1 word/cycle when m_ready is held high and the FIFO is non-empty.
REQ-024 SHALL hold m_data and m_valid stable while m_valid && !m_ready.
REQ-025 SHALL never overflow the buffer, regardless of m_ready stalls; no word shall be lost or duplicated.
REQ-026 SHALL decrement deliver_cnt on each transfer; RUN->DONE on the transfer that brings deliver_cnt to 0.
REQ-027 SHALL assert done for exactly the one cycle in DONE, then go DONE->IDLE.
REQ-028 SHALL handle a simultaneous capture and pop in the same cycle without changing occ.
REQ-029 SHALL, when the FIFO empties mid-burst, stall issuing while fifo_empty is high and resume without a gap once it clears.

Reset
REQ-030 SHALL, when rst_n is low at a clock edge, set state IDLE, occ 0, inflight 0, counters 0, and m_valid, busy, done, fifo_rd_en low.
REQ-031 SHALL drive m_data to 0 after reset.
REQ-032 SHALL, on reset mid-burst, discard buffered and in-flight data; the next burst starts clean.

Configuration
REQ-033 SHALL provide the macro FIFO_BURST_READER_CNT_EN.
REQ-034 With the macro defined, SHALL add output words_sent (width 16) counting all transfers since reset, wrapping 16'hFFFF->0.
REQ-035 Without the macro, SHALL omit the port and counter; all other behaviour is identical.

Verification
REQ-036 SHALL cover: reset, FIFO holds 8 words 01..08, start with burst_len=8, m_ready=1 -> m_data 01..08 on 8 consecutive cycles; done pulses once; busy drops the cycle after.
REQ-037 SHALL cover: burst_len=4, m_ready low for 5 cycles after first m_valid -> fifo_rd_en asserted at most 2 times before first pop; data A1..A4 in order, no loss.
REQ-038 SHALL cover: burst_len=3 with FIFO holding 1 word, 2 more written 4 cycles later -> fifo_rd_en never high while fifo_empty=1; output B1,B2,B3 then done.
REQ-039 SHALL cover: start with burst_len=0 -> done high the next cycle, fifo_rd_en never asserted; a start during RUN is ignored.
REQ-040 SHALL cover: rst_n low 1 cycle mid-burst after 2 of 6 words -> all outputs at reset values the next cycle; a following burst_len=2 returns the next 2 FIFO words.
REQ-041 SHALL cover, with FIFO_BURST_READER_CNT_EN defined: two bursts of 8 and 4 -> words_sent=12.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: reads a burst of burst_len words from a FIFO read port
// (one-cycle read latency) and streams them out over a valid/ready interface
// through a 2-entry in-order skid buffer.
// Optional build macro FIFO_BURST_READER_CNT_EN adds the words_sent output,
// a 16-bit wrapping count of all stream transfers since reset.
module fifo_burst_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
`ifdef FIFO_BURST_READER_CNT_EN
  ,
  output logic [15:0]           words_sent
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  deliver_cnt_q, deliver_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic                  pop;
  logic                  push;
  logic [2:0]            pending;
  logic                  wr_slot1;

  // Handshake decode and read-issue gating: a read is only issued when the
  // word it returns is guaranteed a free buffer slot after this edge.
  always_comb begin
    pop        = (occ_q != 2'd0) && m_ready;
    push       = inflight_q;
    pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = (state_q == ST_RUN) && !fifo_empty &&
                 (issue_cnt_q != '0) && (pending < 3'd2);
  end

  // Next-state logic and the issue/deliver burst counters.
  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    deliver_cnt_d = deliver_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (burst_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d       = ST_RUN;
            issue_cnt_d   = burst_len;
            deliver_cnt_d = burst_len;
          end
        end
      end
      ST_RUN: begin
        if (fifo_rd_en) begin
          issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
        end
        if (pop) begin
          deliver_cnt_d = deliver_cnt_q - LEN_WIDTH'(1);
          if (deliver_cnt_q == LEN_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output buffer: head in buf0, pop shifts buf1 forward, and a returning
  // read lands in the first slot that is free after this cycle's pop.
  always_comb begin
    inflight_d = fifo_rd_en;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    wr_slot1   = (occ_q == 2'd2) || ((occ_q == 2'd1) && !pop);
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (push) begin
      if (wr_slot1) begin
        buf1_d = fifo_rd_data;
      end else begin
        buf0_d = fifo_rd_data;
      end
    end
  end

  // State, counters and buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      issue_cnt_q   <= '0;
      deliver_cnt_q <= '0;
      inflight_q    <= 1'b0;
      occ_q         <= 2'd0;
      buf0_q        <= '0;
      buf1_q        <= '0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      deliver_cnt_q <= deliver_cnt_d;
      inflight_q    <= inflight_d;
      occ_q         <= occ_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
    end
  end

  // Stream and status outputs decoded from registered state.
  always_comb begin
    m_valid = (occ_q != 2'd0);
    m_data  = buf0_q;
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
  end

`ifdef FIFO_BURST_READER_CNT_EN
  logic [15:0] words_sent_q, words_sent_d;

  // Transfer counter, wraps naturally at 16 bits.
  always_comb begin
    words_sent_d = words_sent_q + {15'd0, pop};
  end

  // Transfer counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_sent_q <= '0;
    end else begin
      words_sent_q <= words_sent_d;
    end
  end

  assign words_sent = words_sent_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed and randomized bursts against a behavioural
// model; FIFO contents are tracked as an ordered write log, and every stream
// transfer must return the next word of that log.
module tb_fifo_burst_reader;

  localparam int DW    = 8;
  localparam int LW    = 8;
  localparam int MEMSZ = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;
`ifdef FIFO_BURST_READER_CNT_EN
  logic [15:0]   words_sent;
`endif

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .burst_len    (burst_len),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .done         (done)
`ifdef FIFO_BURST_READER_CNT_EN
    ,
    .words_sent   (words_sent)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: write log in mem, one-cycle read latency.
  logic [DW-1:0] mem [MEMSZ];
  int unsigned   wp = 0;
  int unsigned   rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en && (wp != rp)) begin
      fifo_rd_data <= mem[12'(rp)];
      rp <= rp + 1;
    end
  end

  // Behavioural model and per-cycle checks, sampled mid-cycle.
  bit          mon_en = 0;
  bit          resync = 0;
  bit          act = 0;
  bit          dnext = 0;
  bit          dnew;
  bit          pop_m;
  bit          prev_stall = 0;
  logic [DW-1:0] prev_data;
  int          rem = 0;
  int unsigned exp_idx = 0;
  int          outst = 0;
  int          cyc = 0;
  int          burst_rd = 0;
  int          burst_xf = 0;
  int          done_cnt = 0;
  int          xf_since_rst = 0;
  int          first_rd_cyc = -1;
  int          first_val_cyc = -1;
  int          first_xf_cyc = -1;
  int          last_xf_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      act          = 0;
      dnext        = 0;
      rem          = 0;
      outst        = 0;
      xf_since_rst = 0;
      prev_stall   = 0;
      resync       = 1;
    end else if (mon_en) begin
      if (resync) begin
        exp_idx = rp;
        resync  = 0;
      end
      pop_m = m_valid && m_ready;
      check_eq("done", 32'(done), 32'(dnext));
      check_eq("busy", 32'(busy), 32'(act || dnext));
      check_eq("rd_on_empty", 32'(fifo_rd_en && fifo_empty), 0);
      check_eq("rd_outside_run", 32'(fifo_rd_en && !act), 0);
      check_eq("valid_outside_run", 32'(m_valid && !act), 0);
      if (prev_stall) begin
        check_eq("hold_valid", 32'(m_valid), 1);
        check_eq("hold_data", 32'(m_data), 32'(prev_data));
      end
      outst = outst + int'(fifo_rd_en) - int'(pop_m);
      check_eq("outstanding_le2", 32'(outst <= 2), 1);
      if (fifo_rd_en && act) begin
        if (burst_rd == 0) first_rd_cyc = cyc;
        burst_rd++;
      end
      if (m_valid && act && first_val_cyc < 0) first_val_cyc = cyc;
      if (pop_m) begin
        check_eq("data", 32'(m_data), 32'(mem[12'(exp_idx)]));
        exp_idx++;
        burst_xf++;
        xf_since_rst++;
        if (first_xf_cyc < 0) first_xf_cyc = cyc;
        last_xf_cyc = cyc;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (done) done_cnt++;
      dnew = 0;
      if (act) begin
        if (pop_m) begin
          rem--;
          if (rem == 0) begin
            act  = 0;
            dnew = 1;
          end
        end
      end else if (!dnext && start) begin
        burst_rd      = 0;
        burst_xf      = 0;
        first_rd_cyc  = -1;
        first_val_cyc = -1;
        first_xf_cyc  = -1;
        last_xf_cyc   = -1;
        if (burst_len == '0) dnew = 1;
        else begin
          act = 1;
          rem = int'(burst_len);
        end
      end
      dnext = dnew;
    end
  end

  int rdy_mode = 0;
  bit trickle  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[12'(wp)] = w;
    wp = wp + 1;
  endtask

  task automatic start_burst(input int len);
    burst_len = LW'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    burst_len = '0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (!done && n < budget) begin
      if (trickle && (wp - rp) < 16 && $urandom_range(0, 2) == 0) push(DW'($urandom));
      tick();
      n++;
    end
    if (!done) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int dc0;
  int n;
  int len;

  initial begin
    rst_n = 1'b0; start = 1'b0; burst_len = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;
    check_eq("rst_valid", 32'(m_valid), 0);
    check_eq("rst_data", 32'(m_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 0);

    // Full-rate burst of 8.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    rdy_mode = 1; m_ready = 1'b1; dc0 = done_cnt;
    start_burst(8);
    wait_done(100, "t36");
    tick();
    check_eq("t36_busy_after", 32'(busy), 0);
    check_eq("t36_done_after", 32'(done), 0);
    check_eq("t36_done_pulses", 32'(done_cnt - dc0), 1);
    check_eq("t36_xfers", 32'(burst_xf), 8);
    check_eq("t36_rd_count", 32'(burst_rd), 8);
    check_eq("t36_consecutive", 32'(last_xf_cyc - first_xf_cyc), 7);
    check_eq("t36_latency", 32'(first_val_cyc - first_rd_cyc), 2);

    // Downstream stall: at most two reads before the first pop.
    for (int i = 1; i <= 4; i++) push(DW'(8'hA0 + i));
    rdy_mode = 0; m_ready = 1'b0;
    start_burst(4);
    n = 0;
    while (!m_valid && n < 20) begin tick(); n++; end
    check_eq("t37_valid_seen", 32'(m_valid), 1);
    repeat (5) tick();
    check_eq("t37_rd_before_pop", 32'(burst_rd), 2);
    check_eq("t37_no_pop_yet", 32'(burst_xf), 0);
    rdy_mode = 1; m_ready = 1'b1;
    wait_done(100, "t37");
    tick();
    check_eq("t37_xfers", 32'(burst_xf), 4);
    check_eq("t37_rd_count", 32'(burst_rd), 4);

    // FIFO runs dry mid-burst.
    push(8'hB1);
    dc0 = done_cnt;
    start_burst(3);
    repeat (4) tick();
    push(8'hB2);
    push(8'hB3);
    wait_done(100, "t38");
    tick();
    check_eq("t38_xfers", 32'(burst_xf), 3);
    check_eq("t38_done_pulses", 32'(done_cnt - dc0), 1);

    // Zero-length burst, then a start during RUN.
    dc0 = done_cnt;
    start_burst(0);
    check_eq("t39_done_next", 32'(done), 1);
    check_eq("t39_busy_done", 32'(busy), 1);
    tick();
    check_eq("t39_done_clear", 32'(done), 0);
    check_eq("t39_idle", 32'(busy), 0);
    check_eq("t39_done_pulses", 32'(done_cnt - dc0), 1);
    check_eq("t39_no_reads", 32'(burst_rd), 0);
    push(8'hC1); push(8'hC2); push(8'hC3);
    rdy_mode = 0; m_ready = 1'b0;
    start_burst(2);
    tick();
    burst_len = LW'(5); start = 1'b1;
    tick();
    start = 1'b0; burst_len = '0;
    rdy_mode = 1; m_ready = 1'b1;
    wait_done(100, "t39");
    tick();
    check_eq("t39_xfers", 32'(burst_xf), 2);
    check_eq("t39_fifo_left", 32'(wp - rp), 1);

    // Reset mid-burst after two words.
    for (int i = 1; i <= 6; i++) push(DW'(8'hD0 + i));
    push(8'hE1); push(8'hE2);
    start_burst(6);
    n = 0;
    while (burst_xf < 2 && n < 50) begin tick(); n++; end
    check_eq("t40_two_words", 32'(burst_xf), 2);
    rdy_mode = 0; m_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("t40_valid", 32'(m_valid), 0);
    check_eq("t40_data", 32'(m_data), 0);
    check_eq("t40_busy", 32'(busy), 0);
    check_eq("t40_done", 32'(done), 0);
    check_eq("t40_rd_en", 32'(fifo_rd_en), 0);
`ifdef FIFO_BURST_READER_CNT_EN
    check_eq("t40_words_sent", 32'(words_sent), 0);
`endif
    rdy_mode = 1; m_ready = 1'b1;
    start_burst(2);
    wait_done(100, "t40");
    tick();
    check_eq("t40_xfers", 32'(burst_xf), 2);

`ifdef FIFO_BURST_READER_CNT_EN
    // Transfer counter over two bursts.
    do_reset();
    for (int i = 0; i < 12; i++) push(DW'(8'h30 + i));
    start_burst(8);
    wait_done(100, "t41a");
    tick();
    start_burst(4);
    wait_done(100, "t41b");
    tick();
    check_eq("t41_words_sent", 32'(words_sent), 12);
    check_eq("t41_words_model", 32'(words_sent), 32'(xf_since_rst));
`endif

    // Randomized bursts with random backpressure and FIFO refill.
    trickle = 1;
    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(0, 12);
      n   = $urandom_range(0, len);
      for (int i = 0; i < n; i++) push(DW'($urandom));
      rdy_mode = $urandom_range(1, 2);
      start_burst(len);
      wait_done(400, "rnd");
      tick();
      check_eq("rnd_xfers", 32'(burst_xf), 32'(len));
      check_eq("rnd_rd_count", 32'(burst_rd), 32'(len));
    end
    trickle = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
